// File: rtl/dac_pkg.sv
// Shared definitions for the DAC sample arbiter.
//   SAMPLE_W          : width of one audio sample
//   frame_t           : one stereo frame {left, right}
//   SAT_POS / SAT_NEG : clip limits of the mixer
//   sat_add()         : 16-bit two's complement add, clipped to the limits
package dac_pkg;

  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } frame_t;

  localparam logic [SAMPLE_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [SAMPLE_W-1:0] SAT_NEG = 16'h8000;

  // The sum is formed one bit wider, so it is exact. If the two top bits
  // differ, the result does not fit in 16 bits. Bit 16 then gives the
  // direction of the overflow.
  function automatic logic [SAMPLE_W-1:0] sat_add(input logic [SAMPLE_W-1:0] x,
                                                  input logic [SAMPLE_W-1:0] y);
    logic [SAMPLE_W:0] sum;
    sum = {x[SAMPLE_W-1], x} + {y[SAMPLE_W-1], y};
    if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) begin
      return sum[SAMPLE_W] ? SAT_NEG : SAT_POS;
    end
    return sum[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/stereo_sample_fifo.sv
// Small stereo-frame FIFO with a valid/ready push side and an unconditional pop.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   push_valid_i       : frame offered
//   push_ready_o       : FIFO not full (depends on occupancy only)
//   push_data_i        : frame to store
//   pop_i              : remove the head if not empty (ignored when empty)
//   empty_o            : no frames stored
//   head_o             : oldest stored frame (valid when !empty_o)
//   level_o            : occupancy, 0 .. 2**DEPTH_LOG2
module stereo_sample_fifo
  import dac_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_valid_i,
  output logic                push_ready_o,
  input  frame_t              push_data_i,
  input  logic                pop_i,
  output logic                empty_o,
  output frame_t              head_o,
  output logic [DEPTH_LOG2:0] level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  frame_t                mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  push_acc;
  logic                  pop_acc;

  // Ready is based on the occupancy before the edge. A pop on the same
  // edge therefore never makes room for a push into a full FIFO.
  assign push_ready_o = (level_q != LEVEL_FULL);
  assign empty_o      = (level_q == '0);
  assign push_acc     = push_valid_i && push_ready_o;
  assign pop_acc      = pop_i && !empty_o;
  assign head_o       = mem_q[rd_ptr_q];
  assign level_o      = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_acc, pop_acc})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // The storage has no reset. While the level is 0, its contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/dac_sample_arbiter.sv
// Mixes two stereo sample sources (A = synth, B = PCM/aux) onto the DAC.
//   rst, clk                   : asynchronous active-high reset, clock
//   a_* / b_*                  : per-source valid/ready push of {left,right}
//   a_enable, b_enable         : include the source in the mix
//   next_sample                : 1-cycle pulse, pops one frame per source
//   left_data, right_data      : registered saturated mix, loaded on next_sample
//   a_level, b_level           : FIFO occupancy
//   underrun                   : 1-cycle pulse per source (bit0 A, bit1 B)
module dac_sample_arbiter
  import dac_pkg::*;
#(
  parameter int DEPTH_LOG2    = 2,
  parameter bit UNDERRUN_HOLD = 1'b1
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [15:0]         a_left,
  input  logic [15:0]         a_right,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [15:0]         b_left,
  input  logic [15:0]         b_right,
  input  logic                a_enable,
  input  logic                b_enable,
  input  logic                next_sample,
  output logic [15:0]         left_data,
  output logic [15:0]         right_data,
  output logic [DEPTH_LOG2:0] a_level,
  output logic [DEPTH_LOG2:0] b_level,
  output logic [1:0]          underrun
);

  localparam int NSRC = 2;

  logic [NSRC-1:0]     src_valid;
  logic [NSRC-1:0]     src_ready;
  logic [NSRC-1:0]     src_enable;
  logic [NSRC-1:0]     src_underrun;
  frame_t              src_frame   [NSRC];
  frame_t              src_contrib [NSRC];
  logic [DEPTH_LOG2:0] src_level   [NSRC];

  logic [SAMPLE_W-1:0] left_q, left_d;
  logic [SAMPLE_W-1:0] right_q, right_d;

  assign src_valid    = {b_valid, a_valid};
  assign src_enable   = {b_enable, a_enable};
  assign src_frame[0] = '{left: a_left, right: a_right};
  assign src_frame[1] = '{left: b_left, right: b_right};

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    logic   fifo_empty;
    frame_t fifo_head;
    frame_t held_q, held_d;
    frame_t contrib;
    logic   underrun_q, underrun_d;

    stereo_sample_fifo #(
      .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
      .clk_i       (clk),
      .rst_i       (rst),
      .push_valid_i(src_valid[gi]),
      .push_ready_o(src_ready[gi]),
      .push_data_i (src_frame[gi]),
      .pop_i       (next_sample),
      .empty_o     (fifo_empty),
      .head_o      (fifo_head),
      .level_o     (src_level[gi])
    );

    // A disabled source still drains its FIFO, so its producer keeps running.
    // The source only drops out of the mix and out of the underrun report.
    always_comb begin
      held_d     = held_q;
      underrun_d = 1'b0;
      contrib    = '0;
      if (next_sample) begin
        if (!fifo_empty) begin
          held_d = fifo_head;
          if (src_enable[gi]) contrib = fifo_head;
        end else begin
          underrun_d = src_enable[gi];
          if (src_enable[gi] && UNDERRUN_HOLD) contrib = held_q;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        held_q     <= '0;
        underrun_q <= 1'b0;
      end else begin
        held_q     <= held_d;
        underrun_q <= underrun_d;
      end
    end

    assign src_contrib[gi]  = contrib;
    assign src_underrun[gi] = underrun_q;
  end

  always_comb begin
    left_d  = sat_add(src_contrib[0].left,  src_contrib[1].left);
    right_d = sat_add(src_contrib[0].right, src_contrib[1].right);
  end

  // The DAC interface captures the old value on the same pulse edge.
  // This gives exactly one sample period of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q  <= '0;
      right_q <= '0;
    end else if (next_sample) begin
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign a_ready    = src_ready[0];
  assign b_ready    = src_ready[1];
  assign a_level    = src_level[0];
  assign b_level    = src_level[1];
  assign underrun   = src_underrun;
  assign left_data  = left_q;
  assign right_data = right_q;

endmodule

// File: tb/tb_dac_sample_arbiter.sv
module tb_dac_sample_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [15:0] a_left = '0, a_right = '0, b_left = '0, b_right = '0;
  logic        a_enable = 1'b1, b_enable = 1'b1, next_sample = 1'b0;

  // index 0: UNDERRUN_HOLD=1 instance, index 1: UNDERRUN_HOLD=0 instance
  logic        a_ready_w [2];
  logic        b_ready_w [2];
  logic [15:0] left_w    [2];
  logic [15:0] right_w   [2];
  logic [2:0]  a_level_w [2];
  logic [2:0]  b_level_w [2];
  logic [1:0]  ur_w      [2];

  always #5 clk = ~clk;

  dac_sample_arbiter #(.DEPTH_LOG2(2), .UNDERRUN_HOLD(1'b1)) dut_hold (
    .rst(rst), .clk(clk),
    .a_valid(a_valid), .a_ready(a_ready_w[0]), .a_left(a_left), .a_right(a_right),
    .b_valid(b_valid), .b_ready(b_ready_w[0]), .b_left(b_left), .b_right(b_right),
    .a_enable(a_enable), .b_enable(b_enable), .next_sample(next_sample),
    .left_data(left_w[0]), .right_data(right_w[0]),
    .a_level(a_level_w[0]), .b_level(b_level_w[0]), .underrun(ur_w[0])
  );

  dac_sample_arbiter #(.DEPTH_LOG2(2), .UNDERRUN_HOLD(1'b0)) dut_zero (
    .rst(rst), .clk(clk),
    .a_valid(a_valid), .a_ready(a_ready_w[1]), .a_left(a_left), .a_right(a_right),
    .b_valid(b_valid), .b_ready(b_ready_w[1]), .b_left(b_left), .b_right(b_right),
    .a_enable(a_enable), .b_enable(b_enable), .next_sample(next_sample),
    .left_data(left_w[1]), .right_data(right_w[1]),
    .a_level(a_level_w[1]), .b_level(b_level_w[1]), .underrun(ur_w[1])
  );

  typedef struct packed {
    logic [15:0] lh, rh;   // expected mix, hold variant
    logic [15:0] lz, rz;   // expected mix, zero variant
    logic [1:0]  ur;
    logic [2:0]  al, bl;
  } exp_t;

  exp_t        exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // reference model state
  logic [31:0] mq [2][$];
  logic [31:0] held [2];
  logic [31:0] out_h, out_z;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [15:0] sat(input int x);
    if (x > 32767)  return 16'h7FFF;
    if (x < -32768) return 16'h8000;
    return 16'(x);
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] x, input logic [31:0] y);
    return {sat(sx(x[31:16]) + sx(y[31:16])), sat(sx(x[15:0]) + sx(y[15:0]))};
  endfunction

  // One clock: drive inputs, predict the result of the coming edge, queue it.
  task automatic cycle(input logic av, input logic [31:0] af,
                       input logic bv, input logic [31:0] bf,
                       input logic ae, input logic be, input logic ns,
                       output logic a_acc, output logic b_acc);
    logic [31:0] ch [2];
    logic [31:0] cz [2];
    logic [1:0]  ur;
    logic [1:0]  en;
    exp_t        e;
    @(negedge clk);
    a_valid = av; a_left = af[31:16]; a_right = af[15:0];
    b_valid = bv; b_left = bf[31:16]; b_right = bf[15:0];
    a_enable = ae; b_enable = be; next_sample = ns;
    en    = {be, ae};
    a_acc = av && (mq[0].size() < DEPTH);
    b_acc = bv && (mq[1].size() < DEPTH);
    ur    = 2'b00;
    if (ns) begin
      for (int s = 0; s < 2; s++) begin
        if (mq[s].size() > 0) begin
          held[s] = mq[s].pop_front();
          ch[s]   = en[s] ? held[s] : 32'h0;
          cz[s]   = ch[s];
        end else begin
          ur[s] = en[s];
          ch[s] = en[s] ? held[s] : 32'h0;
          cz[s] = 32'h0;
        end
      end
      out_h = mix(ch[0], ch[1]);
      out_z = mix(cz[0], cz[1]);
    end
    if (a_acc) mq[0].push_back(af);
    if (b_acc) mq[1].push_back(bf);
    e.lh = out_h[31:16]; e.rh = out_h[15:0];
    e.lz = out_z[31:16]; e.rz = out_z[15:0];
    e.ur = ur;
    e.al = 3'(mq[0].size());
    e.bl = 3'(mq[1].size());
    exp_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_left"},     32'(left_w[d]),    32'h0);
      chk({tag, "_right"},    32'(right_w[d]),   32'h0);
      chk({tag, "_a_level"},  32'(a_level_w[d]), 32'h0);
      chk({tag, "_b_level"},  32'(b_level_w[d]), 32'h0);
      chk({tag, "_underrun"}, 32'(ur_w[d]),      32'h0);
      chk({tag, "_ready"},    {30'h0, a_ready_w[d], b_ready_w[d]}, 32'h3);
    end
  endtask

  // Asserted mid-cycle; the checks run before any further clock edge.
  task automatic apply_reset(input string tag);
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check_reset(tag);
    for (int s = 0; s < 2; s++) begin
      mq[s].delete();
      held[s] = 32'h0;
    end
    out_h = 32'h0; out_z = 32'h0;
    repeat (2) @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; next_sample = 1'b0;
    rst = 1'b0;
  endtask

  // Monitor: the DUT presents a new output state after every edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("left_hold",  32'(left_w[0]),  32'(e.lh));
        chk("right_hold", 32'(right_w[0]), 32'(e.rh));
        chk("left_zero",  32'(left_w[1]),  32'(e.lz));
        chk("right_zero", 32'(right_w[1]), 32'(e.rz));
        for (int d = 0; d < 2; d++) begin
          chk("underrun", 32'(ur_w[d]),      32'(e.ur));
          chk("a_level",  32'(a_level_w[d]), 32'(e.al));
          chk("b_level",  32'(b_level_w[d]), 32'(e.bl));
          chk("a_ready",  32'(a_ready_w[d]), 32'(e.al != 3'(DEPTH)));
          chk("b_ready",  32'(b_ready_w[d]), 32'(e.bl != 3'(DEPTH)));
        end
      end
    end
  end

  initial begin : stimulus
    logic        aa, ba;
    logic        pv [2];
    logic [31:0] pf [2];
    held[0] = 32'h0; held[1] = 32'h0; out_h = 32'h0; out_z = 32'h0;
    #1;
    apply_reset("reset_init");

    // basic mix
    cycle(1, 32'h1000F000, 1, 32'h01000010, 1, 1, 0, aa, ba);
    cycle(0, 32'h0,        0, 32'h0,        1, 1, 1, aa, ba);
    cycle(0, 32'h0,        0, 32'h0,        1, 1, 0, aa, ba);

    // saturation in both directions
    cycle(1, 32'h70009000, 1, 32'h2000A000, 1, 1, 0, aa, ba);
    cycle(0, 32'h0,        0, 32'h0,        1, 1, 1, aa, ba);

    // fill A, refuse the 5th push, including on a pop edge
    for (int i = 0; i < 4; i++) cycle(1, 32'hA0000000 + i, 0, 32'h0, 1, 1, 0, aa, ba);
    cycle(1, 32'hA5A5A5A5, 0, 32'h0, 1, 1, 0, aa, ba);
    cycle(1, 32'hA5A5A5A5, 0, 32'h0, 1, 1, 1, aa, ba);
    cycle(1, 32'hA5A5A5A5, 0, 32'h0, 1, 1, 0, aa, ba);

    // drain A, then underrun after popping 0x1234 with B disabled
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 0, 32'h0, 1, 0, 1, aa, ba);
    cycle(1, 32'h12341234, 0, 32'h0, 1, 0, 0, aa, ba);
    cycle(0, 32'h0,        0, 32'h0, 1, 0, 1, aa, ba);
    cycle(0, 32'h0,        0, 32'h0, 1, 0, 1, aa, ba);
    cycle(0, 32'h0,        0, 32'h0, 1, 0, 0, aa, ba);

    // push and pop on the same edge into an empty A
    cycle(1, 32'h55553333, 0, 32'h0, 1, 0, 1, aa, ba);
    cycle(0, 32'h0,        0, 32'h0, 1, 0, 1, aa, ba);

    // both FIFOs at level 3, then an asynchronous reset
    for (int i = 0; i < 3; i++) cycle(1, $urandom, 1, $urandom, 1, 1, 0, aa, ba);
    @(posedge clk);
    #2;
    apply_reset("reset_mid");

    // randomized traffic: producers hold data until accepted
    pv[0] = 1'b0; pv[1] = 1'b0; pf[0] = 32'h0; pf[1] = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      for (int s = 0; s < 2; s++) begin
        if (!pv[s] && ($urandom_range(0, 2) == 0)) begin
          pv[s] = 1'b1;
          pf[s] = $urandom;
        end
      end
      cycle(pv[0], pf[0], pv[1], pf[1],
            logic'($urandom_range(0, 5) != 0), logic'($urandom_range(0, 5) != 0),
            logic'($urandom_range(0, (n < 1500) ? 3 : 1) == 0), aa, ba);
      if (aa) pv[0] = 1'b0;
      if (ba) pv[1] = 1'b0;
    end

    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; next_sample = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
